// File: rtl/csr_trap_sequencer.sv
// Sole owner of the CSR file port: arbitrates CSR instructions, trap entry and mret,
// and steps through the fixed trap/return write sequences, issuing the PC redirect.
package csr_trap_pkg;
  typedef enum logic {REG_NO_WE = 1'b0, REG_WE = 1'b1} reg_we_e;
endpackage

module csr_trap_sequencer
  import csr_trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_tval,
  output logic        trap_ack,
  input  logic        mret_req,
  output logic        mret_ack,
  input  logic        csr_req_valid,
  output logic        csr_req_ready,
  input  logic [1:0]  csr_req_op,
  input  logic        csr_req_wr,
  input  logic [11:0] csr_req_addr,
  input  logic [31:0] csr_req_wdata,
  output logic        csr_rsp_valid,
  output logic [31:0] csr_rsp_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output reg_we_e     csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CSR_ACC, S_T_EPC, S_T_CAUSE, S_T_TVAL, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC
  } state_e;

  state_e      r_state;
  logic [1:0]  r_op;
  logic        r_wr;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;

  logic        w_idle;
  reg_we_e     w_we;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_vec_target;

  assign w_idle        = (r_state == S_IDLE);
  assign busy          = !w_idle;
  assign trap_ack      = rst_n && w_idle && trap_req;
  assign mret_ack      = rst_n && w_idle && !trap_req && mret_req;
  assign csr_req_ready = rst_n && w_idle && !trap_req && !mret_req;

  // Vectored mode only applies to interrupts (cause[31]); 4*cause[30:0] wraps at 32 bits.
  assign w_vec_target = {csr_rdata[31:2], 2'b00} +
                        (((csr_rdata[1:0] == 2'b01) && r_cause[31]) ? {r_cause[29:0], 2'b00} : 32'd0);

  // The CSR file read is combinational, so read-modify-write completes within one state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_we    = REG_NO_WE;
    w_addr  = '0;
    w_wdata = '0;
    case (r_state)
      S_CSR_ACC: begin
        w_addr = r_addr;
        case (r_op)
          OP_RW:   w_wdata = r_wdata;
          OP_RS:   w_wdata = csr_rdata | r_wdata;
          OP_RC:   w_wdata = csr_rdata & ~r_wdata;
          default: w_wdata = csr_rdata;
        endcase
        if (r_wr && (r_op != OP_READ)) w_we = REG_WE;
      end
      S_T_EPC:   begin w_addr = ADDR_MEPC;   w_wdata = {r_pc[31:2], 2'b00}; w_we = REG_WE; end
      S_T_CAUSE: begin w_addr = ADDR_MCAUSE; w_wdata = r_cause;             w_we = REG_WE; end
      S_T_TVAL:  begin w_addr = ADDR_MTVAL;  w_wdata = r_tval;              w_we = REG_WE; end
      S_T_STAT: begin
        w_addr        = ADDR_MSTATUS;
        w_wdata       = csr_rdata;
        w_wdata[7]    = csr_rdata[3];
        w_wdata[3]    = 1'b0;
        w_wdata[12:11] = 2'b11;
        w_we          = REG_WE;
      end
      S_T_VEC:   w_addr = ADDR_MTVEC;
      S_R_STAT: begin
        w_addr        = ADDR_MSTATUS;
        w_wdata       = csr_rdata;
        w_wdata[3]    = csr_rdata[7];
        w_wdata[7]    = 1'b1;
        w_wdata[12:11] = 2'b11;
        w_we          = REG_WE;
      end
      S_R_EPC:   w_addr = ADDR_MEPC;
      default:   ;
    endcase
  end

  // Reset held low blocks the write of the cycle it lands in, so an aborted sequence stops cleanly.
  assign csr_we    = rst_n ? w_we : REG_NO_WE;
  assign csr_addr  = w_addr;
  assign csr_wdata = w_wdata;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_op           <= OP_READ;
      r_wr           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_pc           <= '0;
      r_cause        <= '0;
      r_tval         <= '0;
      csr_rsp_valid  <= 1'b0;
      csr_rsp_rdata  <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_rsp_valid  <= 1'b0;
      redirect_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (trap_req) begin
            r_pc    <= trap_pc;
            r_cause <= trap_cause;
            r_tval  <= trap_tval;
            r_state <= S_T_EPC;
          end else if (mret_req) begin
            r_state <= S_R_STAT;
          end else if (csr_req_valid) begin
            r_op    <= csr_req_op;
            r_wr    <= csr_req_wr;
            r_addr  <= csr_req_addr;
            r_wdata <= csr_req_wdata;
            r_state <= S_CSR_ACC;
          end
        end
        S_CSR_ACC: begin
          csr_rsp_valid <= 1'b1;
          csr_rsp_rdata <= csr_rdata;
          r_state       <= S_IDLE;
        end
        S_T_EPC:   r_state <= S_T_CAUSE;
        S_T_CAUSE: r_state <= S_T_TVAL;
        S_T_TVAL:  r_state <= S_T_STAT;
        S_T_STAT:  r_state <= S_T_VEC;
        S_T_VEC: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= w_vec_target;
          r_state        <= S_IDLE;
        end
        S_R_STAT:  r_state <= S_R_EPC;
        S_R_EPC: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= {csr_rdata[31:2], 2'b00};
          r_state        <= S_IDLE;
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end
endmodule
